mem_stage: RTL and testbench

Memory stage of the five-stage pipeline, directly downstream of the execute stage. Accepts one executed instruction per cycle (ALU result, store data, control bits, flags), performs data-memory loads/stores through a request/acknowledge handshake, stalls execute while an access is outstanding, and hands one result per retired instruction to write-back. Also owns the architectural condition-code register (CCR).

---
 rtl/mem_stage.sv | 107 ++++++++++
 tb/tb_mem_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage: retires ALU results directly, runs loads/stores over a req/ack
// handshake while stalling execute, and owns the condition-code register.
module mem_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_wb_en,
  input  logic [2:0]        ex_rdst,
  input  logic              ex_flag_en,
  input  logic [2:0]        ex_flags,
  input  logic              flush,
  output logic              ex_stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_ack,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [2:0]        wb_rdst,
  output logic [DATA_W-1:0] wb_data,
  output logic [2:0]        ccr
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state;
  logic              squash;
  logic              wb_en_lat;
  logic [2:0]        rdst_lat;
  logic [DATA_W-1:0] alu_lat;

  assign ex_stall = (state == ACCESS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      squash    <= 1'b0;
      wb_en_lat <= 1'b0;
      rdst_lat  <= '0;
      alu_lat   <= '0;
      dm_req    <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= '0;
      dm_wdata  <= '0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rdst   <= '0;
      wb_data   <= '0;
      ccr       <= 3'b000;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid && !flush) begin
            if (ex_flag_en) ccr <= ex_flags;
            if (ex_mem_read || ex_mem_write) begin
              // A request with both read and write set is issued as a store.
              wb_en_lat <= ex_wb_en;
              rdst_lat  <= ex_rdst;
              alu_lat   <= ex_alu_out;
              squash    <= 1'b0;
              dm_req    <= 1'b1;
              dm_we     <= ex_mem_write;
              dm_addr   <= ex_alu_out[ADDR_W-1:0];
              dm_wdata  <= ex_store_data;
              state     <= ACCESS;
            end else begin
              wb_valid <= 1'b1;
              wb_we    <= ex_wb_en;
              wb_data  <= ex_alu_out;
              wb_rdst  <= ex_rdst;
            end
          end
        end
        ACCESS: begin
          if (dm_ack) begin
            dm_req <= 1'b0;
            dm_we  <= 1'b0;
            squash <= 1'b0;
            state  <= IDLE;
            // A flush coinciding with the ack also squashes the retire.
            if (!(squash || flush)) begin
              wb_valid <= 1'b1;
              wb_we    <= wb_en_lat && !dm_we;
              wb_data  <= dm_we ? alu_lat : dm_rdata;
              wb_rdst  <= rdst_lat;
            end
          end else if (flush) begin
            squash <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboarded bench for mem_stage: directed ALU, load, store, flush and reset cases.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_wb_en, ex_flag_en, flush;
  logic [15:0] ex_alu_out, ex_store_data, dm_rdata, wb_data, dm_wdata;
  logic [2:0]  ex_rdst, ex_flags, wb_rdst, ccr;
  logic        ex_stall, dm_req, dm_we, dm_ack, wb_valid, wb_we;
  logic [11:0] dm_addr;

  typedef struct packed {
    logic        we;
    logic [2:0]  rdst;
    logic [15:0] data;
  } wb_t;

  wb_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.DATA_W(16), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_wb_en(ex_wb_en),
    .ex_rdst(ex_rdst), .ex_flag_en(ex_flag_en), .ex_flags(ex_flags), .flush(flush),
    .ex_stall(ex_stall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rdst(wb_rdst), .wb_data(wb_data), .ccr(ccr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every retire pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (wb_valid) begin
      wb_t e;
      if (exp_q.size() == 0) begin
        chk("unexpected_retire", 32'(wb_valid), 32'(1'b0));
      end else begin
        e = exp_q.pop_front();
        chk("wb_we", 32'(wb_we), 32'(e.we));
        chk("wb_rdst", 32'(wb_rdst), 32'(e.rdst));
        chk("wb_data", 32'(wb_data), 32'(e.data));
        $display("retire rdst=%0d we=%0b data=%h", wb_rdst, wb_we, wb_data);
      end
    end else if (wb_we) begin
      chk("wb_we_without_valid", 32'(wb_we), 32'(1'b0));
    end
  end

  task automatic drive(input logic [15:0] alu, input logic [15:0] sdata, input logic rd,
                       input logic wr, input logic wben, input logic [2:0] rdst,
                       input logic fen, input logic [2:0] flags);
    ex_valid = 1'b1; ex_alu_out = alu; ex_store_data = sdata; ex_mem_read = rd;
    ex_mem_write = wr; ex_wb_en = wben; ex_rdst = rdst; ex_flag_en = fen; ex_flags = flags;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_alu_out = 16'hFFFF; ex_store_data = 16'hFFFF; ex_mem_read = 1'b0;
    ex_mem_write = 1'b0; ex_wb_en = 1'b0; ex_rdst = 3'd0; ex_flag_en = 1'b0; ex_flags = 3'b000;
  endtask

  // Present one instruction for a single accepting edge, then go idle.
  task automatic issue(input logic [15:0] alu, input logic [15:0] sdata, input logic rd,
                       input logic wr, input logic wben, input logic [2:0] rdst,
                       input logic fen, input logic [2:0] flags);
    drive(alu, sdata, rd, wr, wben, rdst, fen, flags);
    $display("issue alu=%h sdata=%h rd=%0b wr=%0b wb_en=%0b rdst=%0d", alu, sdata, rd, wr, wben, rdst);
    @(negedge clk);
    idle_inputs();
  endtask

  // Hold through k cycles of ACCESS, checking the request stays stable, ack on the last.
  task automatic mem_wait(input logic we_exp, input logic [11:0] addr_exp,
                          input logic [15:0] wdata_exp, input int k,
                          input logic [15:0] rdata, input logic do_flush);
    for (int i = 0; i < k; i++) begin
      chk("dm_req_held", 32'(dm_req), 32'(1'b1));
      chk("dm_we_held", 32'(dm_we), 32'(we_exp));
      chk("dm_addr_held", 32'(dm_addr), 32'(addr_exp));
      chk("dm_wdata_held", 32'(dm_wdata), 32'(wdata_exp));
      chk("ex_stall_access", 32'(ex_stall), 32'(1'b1));
      flush = (do_flush && i == 0);
      if (i == k - 1) begin
        dm_ack = 1'b1;
        dm_rdata = rdata;
      end
      @(negedge clk);
    end
    flush = 1'b0;
    dm_ack = 1'b0;
    dm_rdata = 16'h0BAD;
    chk("dm_req_released", 32'(dm_req), 32'(1'b0));
    chk("ex_stall_released", 32'(ex_stall), 32'(1'b0));
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; dm_ack = 1'b0; dm_rdata = 16'h0;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk("rst_ex_stall", 32'(ex_stall), 32'(1'b0));
    chk("rst_dm_req", 32'(dm_req), 32'(1'b0));
    chk("rst_dm_addr", 32'(dm_addr), 32'(12'h000));
    chk("rst_wb_valid", 32'(wb_valid), 32'(1'b0));
    chk("rst_wb_data", 32'(wb_data), 32'(16'h0000));
    chk("rst_ccr", 32'(ccr), 32'(3'b000));
    rst = 1'b1;
    @(negedge clk);

    // ALU op
    exp_q.push_back('{we: 1'b1, rdst: 3'd3, data: 16'h1234});
    issue(16'h1234, 16'h0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 3'b010);
    chk("alu_ccr", 32'(ccr), 32'(3'b010));
    chk("alu_no_stall", 32'(ex_stall), 32'(1'b0));
    chk("alu_wb_valid", 32'(wb_valid), 32'(1'b1));

    // Load, ack three cycles after dm_req rises
    exp_q.push_back('{we: 1'b1, rdst: 3'd5, data: 16'hBEEF});
    issue(16'h0040, 16'h1357, 1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 3'b000);
    mem_wait(1'b0, 12'h040, 16'h1357, 3, 16'hBEEF, 1'b0);
    chk("load_ccr_kept", 32'(ccr), 32'(3'b010));

    // Store, ack after one cycle; register write suppressed
    exp_q.push_back('{we: 1'b0, rdst: 3'd2, data: 16'h0005});
    issue(16'h0005, 16'hA5A5, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 3'b000);
    mem_wait(1'b1, 12'h005, 16'hA5A5, 1, 16'h7777, 1'b0);

    // Read and write both set behaves as a store
    exp_q.push_back('{we: 1'b0, rdst: 3'd1, data: 16'h3ABC});
    issue(16'h3ABC, 16'h4444, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 3'b000);
    mem_wait(1'b1, 12'hABC, 16'h4444, 2, 16'h9999, 1'b0);

    // Flush during ACCESS: access completes, no retire; next op retires
    issue(16'h0010, 16'h2222, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 3'b000);
    mem_wait(1'b0, 12'h010, 16'h2222, 2, 16'hDEAD, 1'b1);
    chk("flush_no_retire", 32'(wb_valid), 32'(1'b0));
    exp_q.push_back('{we: 1'b1, rdst: 3'd6, data: 16'h0777});
    issue(16'h0777, 16'h0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 3'b000);
    chk("after_flush_retire", 32'(wb_valid), 32'(1'b1));

    // Flush in IDLE drops the instruction including its CCR write
    drive(16'h5555, 16'h0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b1, 3'b111);
    flush = 1'b1;
    $display("issue flushed alu=5555 in idle");
    @(negedge clk);
    flush = 1'b0;
    idle_inputs();
    chk("idle_flush_ccr", 32'(ccr), 32'(3'b010));
    chk("idle_flush_no_retire", 32'(wb_valid), 32'(1'b0));

    // dm_ack while IDLE is ignored
    dm_ack = 1'b1; dm_rdata = 16'h6666;
    @(negedge clk);
    dm_ack = 1'b0;
    chk("idle_ack_no_req", 32'(dm_req), 32'(1'b0));
    chk("idle_ack_no_retire", 32'(wb_valid), 32'(1'b0));

    // Async reset mid-access; the late ack must produce nothing
    issue(16'h0123, 16'h8888, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 3'b101);
    chk("pre_rst_ccr", 32'(ccr), 32'(3'b101));
    chk("pre_rst_stall", 32'(ex_stall), 32'(1'b1));
    #2 rst = 1'b0;
    #1;
    chk("async_dm_req", 32'(dm_req), 32'(1'b0));
    chk("async_ex_stall", 32'(ex_stall), 32'(1'b0));
    chk("async_wb_valid", 32'(wb_valid), 32'(1'b0));
    chk("async_ccr", 32'(ccr), 32'(3'b000));
    chk("async_dm_addr", 32'(dm_addr), 32'(12'h000));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    dm_ack = 1'b1; dm_rdata = 16'h1111;
    @(negedge clk);
    dm_ack = 1'b0;
    chk("late_ack_no_req", 32'(dm_req), 32'(1'b0));
    chk("late_ack_no_stall", 32'(ex_stall), 32'(1'b0));
    chk("late_ack_no_retire", 32'(wb_valid), 32'(1'b0));

    // Four back-to-back ALU ops
    for (int i = 0; i < 4; i++) begin
      logic [15:0] v;
      v = 16'h1000 + 16'(i * 16'h0111);
      exp_q.push_back('{we: (i != 2), rdst: 3'(i + 1), data: v});
      drive(v, 16'h0, 1'b0, 1'b0, (i != 2), 3'(i + 1), 1'b0, 3'b000);
      $display("issue b2b alu=%h rdst=%0d", v, i + 1);
      @(negedge clk);
      chk("b2b_wb_valid", 32'(wb_valid), 32'(1'b1));
      chk("b2b_no_stall", 32'(ex_stall), 32'(1'b0));
    end
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
